// File: rtl/issue_execute_fifo_if.sv
// ============================================================================
// Module    : issue_execute_fifo_pkg / issue_execute_fifo_if
// Purpose   : Entry type and hand-off bundle between the issue stage, one
//             execute unit and the commit flush for issue_execute_fifo.
// Signals   : data_in/push        issue -> FIFO enqueue request
//             full                FIFO -> issue, no free entry (registered)
//             data_out/_valid     FIFO -> execute, oldest entry
//             pop                 execute -> FIFO, consume data_out
//             flush               commit -> FIFO, discard all entries
// Modports  : master (environment: issue + execute + commit), slave (FIFO)
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

package issue_execute_fifo_pkg;
  typedef struct packed {
    logic [5:0]  rob_id;
    logic [31:0] pc;
    logic [7:0]  opcode;
  } issue_execute_pack_t;
endpackage

interface issue_execute_fifo_if;
  import issue_execute_fifo_pkg::*;

  issue_execute_pack_t data_in;
  logic                push;
  logic                full;
  issue_execute_pack_t data_out;
  logic                data_out_valid;
  logic                pop;
  logic                flush;

  // The master side is shared by three agents (issue drives push/data_in,
  // execute drives pop, commit drives flush); they are grouped here so one
  // bundle describes the complete hand-off.
  modport master (
    output data_in, push, pop, flush,
    input  full, data_out, data_out_valid
  );

  modport slave (
    input  data_in, push, pop, flush,
    output full, data_out, data_out_valid
  );
endinterface

`default_nettype wire

// File: rtl/issue_execute_fifo.sv
// ============================================================================
// Module    : issue_execute_fifo
// Purpose   : Issue->execute entry buffer. Issue pushes packs, the execute
//             unit sees the oldest one on data_out and drains it with pop,
//             commit flush empties the queue.
// Ports     : clk      clock, all state updates on posedge
//             rst      synchronous active-high reset (priority over flush)
//             fifo_if  issue_execute_fifo_if.slave hand-off bundle
// Params    : DEPTH      entry count, power of 2, >= 2
//             ADDR_WIDTH storage index width; pointers carry one wrap bit
// Config    : ISSUE_EXECUTE_FIFO_BYPASS_EN - when defined, an empty FIFO
//             forwards data_in to data_out in the same cycle as the push.
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

module issue_execute_fifo
  import issue_execute_fifo_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  issue_execute_fifo_if.slave   fifo_if
);

  localparam int PTR_W = ADDR_WIDTH + 1;

  logic [PTR_W-1:0]      wptr_q, wptr_d;
  logic [PTR_W-1:0]      rptr_q, rptr_d;
  issue_execute_pack_t   storage_q [DEPTH];

  logic [ADDR_WIDTH-1:0] widx, ridx;
  logic                  empty;
  logic                  full;
  logic                  bypass_hit;
  logic                  bypass_take;
  logic                  out_valid;
  logic                  pop_fire;
  logic                  push_fire;
  logic                  wr_en;

  assign widx  = wptr_q[ADDR_WIDTH-1:0];
  assign ridx  = rptr_q[ADDR_WIDTH-1:0];
  assign empty = (wptr_q == rptr_q);
  // Same slot but opposite lap: the writer is exactly DEPTH entries ahead.
  assign full  = (widx == ridx) && (wptr_q[ADDR_WIDTH] != rptr_q[ADDR_WIDTH]);

`ifdef ISSUE_EXECUTE_FIFO_BYPASS_EN
  // Empty queue: the incoming entry is already the oldest one, so show it
  // immediately instead of waiting for it to land in storage.
  assign bypass_hit = empty && fifo_if.push && !fifo_if.flush;
`else
  assign bypass_hit = 1'b0;
`endif

  // A bypassed entry that execute takes in the same cycle never touches
  // storage; both pointers stay put.
  assign bypass_take = bypass_hit && fifo_if.pop;

  assign out_valid = !empty || bypass_hit;
  assign pop_fire  = fifo_if.pop && out_valid;
  // A full FIFO can still accept a push when a slot frees up this cycle.
  assign push_fire = fifo_if.push && (!full || pop_fire);

  assign fifo_if.full           = full;
  assign fifo_if.data_out_valid = out_valid;
  assign fifo_if.data_out       = bypass_hit ? fifo_if.data_in : storage_q[ridx];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    wr_en  = 1'b0;
    if (fifo_if.flush) begin
      wptr_d = '0;
      rptr_d = '0;
    end else if (!bypass_take) begin
      if (push_fire) begin
        wr_en  = 1'b1;
        wptr_d = wptr_q + PTR_W'(1);
      end
      if (pop_fire) begin
        rptr_d = rptr_q + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage is deliberately not reset: contents are only observable
  // through data_out while data_out_valid is set.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      storage_q[widx] <= fifo_if.data_in;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_issue_execute_fifo.sv
// ============================================================================
// Module    : tb_issue_execute_fifo
// Purpose   : Self-checking bench for issue_execute_fifo. A queue-based
//             reference model predicts full/data_out_valid/data_out every
//             cycle; directed steps cover reset, fill, drop, wrap, flush and
//             bypass, followed by a randomized run.
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_issue_execute_fifo;
  import issue_execute_fifo_pkg::*;

  localparam int DEPTH = 4;
`ifdef ISSUE_EXECUTE_FIFO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  issue_execute_fifo_if bus ();

  issue_execute_fifo #(.DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .fifo_if (bus)
  );

  issue_execute_pack_t mq [$];
  int n_checks = 0;
  int n_errors = 0;

  function automatic issue_execute_pack_t mk(input int rob);
    issue_execute_pack_t p;
    p.rob_id = 6'(rob);
    p.pc     = $urandom;
    p.opcode = 8'($urandom);
    return p;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: apply inputs, compare outputs mid-cycle against the model,
  // then advance the model with the queue rules for that edge.
  task automatic cycle(input logic r, input logic p, input issue_execute_pack_t d,
                       input logic po, input logic fl);
    bit                  e_valid, byp_now, popf, pushf;
    issue_execute_pack_t e_data;
    rst = r; bus.push = p; bus.data_in = d; bus.pop = po; bus.flush = fl;
    @(negedge clk);
    byp_now = BYP && (mq.size() == 0) && p && !fl;
    e_valid = (mq.size() > 0) || byp_now;
    e_data  = (mq.size() > 0) ? mq[0] : d;
    if (!r) begin
      chk("full", 64'(bus.full), 64'(mq.size() == DEPTH));
      chk("valid", 64'(bus.data_out_valid), 64'(e_valid));
      if (e_valid) chk("data_out", 64'(bus.data_out), 64'(e_data));
    end
    if (r || fl) begin
      mq.delete();
    end else if (!(byp_now && po)) begin
      popf  = po && (mq.size() > 0);
      pushf = p && ((mq.size() < DEPTH) || popf);
      if (popf)  void'(mq.pop_front());
      if (pushf) mq.push_back(d);
    end
    @(posedge clk);
    #1;
  endtask

  // Constant expectations from the directed scenarios, sampled with idle inputs.
  task automatic expect_state(input string tag, input logic e_full, input logic e_valid,
                              input int e_rob);
    issue_execute_pack_t idle;
    idle = mk(0);
    bus.push = 1'b0; bus.pop = 1'b0; bus.flush = 1'b0; bus.data_in = idle;
    #2;
    chk({tag, "_full"}, 64'(bus.full), 64'(e_full));
    chk({tag, "_valid"}, 64'(bus.data_out_valid), 64'(e_valid));
    if (e_valid) chk({tag, "_rob"}, 64'(bus.data_out.rob_id), 64'(6'(e_rob)));
  endtask

  initial begin
    rst = 1'b1;
    bus.push = 1'b0; bus.pop = 1'b0; bus.flush = 1'b0; bus.data_in = mk(0);
    @(posedge clk);
    #1;

    // Reset, then pop while empty is ignored.
    cycle(1, 0, mk(0), 0, 0);
    expect_state("reset", 0, 0, 0);
    cycle(0, 0, mk(0), 1, 0);
    expect_state("pop_empty", 0, 0, 0);

    // Fill to DEPTH, then an illegal push while full is dropped.
    for (int i = 1; i <= 4; i++) cycle(0, 1, mk(i), 0, 0);
    expect_state("filled", 1, 1, 1);
    cycle(0, 1, mk(5), 0, 0);
    expect_state("drop", 1, 1, 1);

    // Push+pop while full is accepted.
    cycle(0, 1, mk(5), 1, 0);
    expect_state("full_pushpop", 1, 1, 2);
    for (int i = 0; i < 4; i++) cycle(0, 0, mk(0), 1, 0);
    expect_state("drained", 0, 0, 0);

    // Streaming at occupancy 1: pointers wrap repeatedly.
    cycle(0, 1, mk(10), 0, 0);
    for (int i = 11; i <= 20; i++) cycle(0, 1, mk(i), 1, 0);
    expect_state("stream", 0, 1, 20);
    cycle(0, 0, mk(0), 1, 0);

    // Flush with a concurrent push discards everything.
    for (int i = 1; i <= 3; i++) cycle(0, 1, mk(i), 0, 0);
    cycle(0, 1, mk(9), 0, 1);
    expect_state("flush", 0, 0, 0);
    cycle(0, 0, mk(0), 1, 0);
    expect_state("post_flush", 0, 0, 0);

    // Push+pop on an empty FIFO: consumed by bypass, or stored otherwise.
    cycle(0, 1, mk(7), 1, 0);
    if (BYP) expect_state("byp_after", 0, 0, 0);
    else     expect_state("nobyp_after", 0, 1, 7);
    cycle(0, 0, mk(0), 1, 0);

    // Reset mid-stream drops all entries.
    cycle(0, 1, mk(30), 0, 0);
    cycle(0, 1, mk(31), 0, 0);
    cycle(1, 1, mk(32), 0, 0);
    expect_state("rst_mid", 0, 0, 0);

    // Randomized traffic; pushes while full without pop are avoided.
    for (int i = 0; i < 400; i++) begin
      logic p, po, fl, r;
      po = ($urandom_range(0, 99) < 50);
      p  = ($urandom_range(0, 99) < 60);
      fl = ($urandom_range(0, 99) < 4);
      r  = ($urandom_range(0, 99) < 2);
      if (mq.size() == DEPTH && !po) p = 1'b0;
      cycle(r, p, mk($urandom_range(0, 63)), po, fl);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
